// File: rtl/lru_replace_ctrl.sv
// lru_replace_ctrl
//   Replacement controller for a 4-way set-associative cache. Holds a 2-bit
//   age per way per set (3 = most recent, 0 = LRU) plus a valid bit per way.
//   Lookups are serialised through IDLE -> UPDATE -> RESP, one per 3 cycles.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-high reset
//   flush       clears valid bits and re-initialises ages (acted on in IDLE)
//   req_valid   lookup result available
//   req_ready   controller can accept a lookup result
//   req_set     set index of the access
//   req_hit     1 = tag hit, 0 = miss
//   req_way     hit way (ignored on a miss)
//   done        one-cycle pulse when the update is complete
//   done_way    way touched (hit way or chosen victim), valid with done
//   done_evict  miss replaced a valid line, valid with done
//   err         hit reported on an invalid way, valid with done

module lru_replace_ctrl #(
    parameter int unsigned NUM_SETS = 8,
    parameter int unsigned SET_W    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [SET_W-1:0] req_set,
    input  logic             req_hit,
    input  logic [1:0]       req_way,
    output logic             done,
    output logic [1:0]       done_way,
    output logic             done_evict,
    output logic             err
);

    typedef enum logic [1:0] {StIdle, StUpdate, StResp} state_e;

    typedef logic [NUM_SETS-1:0][3:0][1:0] age_arr_t;

    // Every set starts with age == way index, a valid permutation of 0..3.
    function automatic age_arr_t init_ages();
        age_arr_t a;
        for (int s = 0; s < int'(NUM_SETS); s++) begin
            for (int w = 0; w < 4; w++) begin
                a[s][w] = 2'(w);
            end
        end
        return a;
    endfunction

    localparam age_arr_t AgeInit = init_ages();

    state_e                     state_q, state_d;
    age_arr_t                   age_q, age_d;
    logic [NUM_SETS-1:0][3:0]   valid_q, valid_d;
    logic [SET_W-1:0]           set_q, set_d;
    logic                       hit_q, hit_d;
    logic [1:0]                 way_q, way_d;
    logic                       evict_q, evict_d;
    logic                       err_q, err_d;

    logic [3:0][1:0]            cur_age;
    logic [3:0]                 cur_valid;
    logic [1:0]                 target;
    logic [1:0]                 tgt_age;

    // Target selection for the captured request.
    always_comb begin
        cur_age   = age_q[set_q];
        cur_valid = valid_q[set_q];
        target    = 2'd0;
        if (hit_q) begin
            target = way_q;
        end else if (!(&cur_valid)) begin
            // Descending scan so the lowest invalid index wins.
            for (int w = 3; w >= 0; w--) begin
                if (!cur_valid[w]) target = 2'(w);
            end
        end else begin
            for (int w = 0; w < 4; w++) begin
                if (cur_age[w] == 2'd0) target = 2'(w);
            end
        end
        tgt_age = cur_age[target];
    end

    always_comb begin
        state_d = state_q;
        age_d   = age_q;
        valid_d = valid_q;
        set_d   = set_q;
        hit_d   = hit_q;
        way_d   = way_q;
        evict_d = evict_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (flush) begin
                    age_d   = AgeInit;
                    valid_d = '0;
                end else if (req_valid) begin
                    set_d   = req_set;
                    hit_d   = req_hit;
                    way_d   = req_way;
                    state_d = StUpdate;
                end
            end
            StUpdate: begin
                // Only ages above the target's old age move down, which keeps
                // the set a permutation and prevents underflow.
                for (int w = 0; w < 4; w++) begin
                    if (2'(w) == target) begin
                        age_d[set_q][w] = 2'd3;
                    end else if (cur_age[w] > tgt_age) begin
                        age_d[set_q][w] = cur_age[w] - 2'd1;
                    end
                end
                valid_d[set_q][target] = 1'b1;
                way_d   = target;
                evict_d = !hit_q && (&cur_valid);
                err_d   = hit_q && !cur_valid[target];
                state_d = StResp;
            end
            StResp: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            age_q   <= AgeInit;
            valid_q <= '0;
            set_q   <= '0;
            hit_q   <= 1'b0;
            way_q   <= 2'd0;
            evict_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            age_q   <= age_d;
            valid_q <= valid_d;
            set_q   <= set_d;
            hit_q   <= hit_d;
            way_q   <= way_d;
            evict_q <= evict_d;
            err_q   <= err_d;
        end
    end

    assign req_ready  = (state_q == StIdle) && !flush && !reset;
    assign done       = (state_q == StResp);
    assign done_way   = done ? way_q : 2'd0;
    assign done_evict = done && evict_q;
    assign err        = done && err_q;

endmodule

// File: tb/tb_lru_replace_ctrl.sv
module tb_lru_replace_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       flush;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_set;
    logic       req_hit;
    logic [1:0] req_way;
    logic       done;
    logic [1:0] done_way;
    logic       done_evict;
    logic       err;

    int vectors    = 0;
    int miscompares = 0;

    lru_replace_ctrl #(.NUM_SETS(8), .SET_W(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_set    (req_set),
        .req_hit    (req_hit),
        .req_way    (req_way),
        .done       (done),
        .done_way   (done_way),
        .done_evict (done_evict),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Issues one request and returns the response plus the cycle on which
    // done was seen (acceptance cycle = 0). lat reaches 10 on timeout.
    task automatic do_req(input logic [2:0] s, input logic h, input logic [1:0] w,
                          output logic [1:0] o_way, output logic o_ev,
                          output logic o_err, output int lat);
        int n;
        req_set   = s;
        req_hit   = h;
        req_way   = w;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!done && lat < 10) begin
            @(posedge clk); #1; lat++;
        end
        o_way = done_way;
        o_ev  = done_evict;
        o_err = err;
    endtask

    task automatic test_reset();
        logic [7:0] exp_age;
        exp_age = {2'd3, 2'd2, 2'd1, 2'd0};
        for (int s = 0; s < 8; s++) begin
            vectors++;
            if (dut.age_q[s] !== exp_age) begin
                miscompares++;
                $display("FAIL reset_age set %0d: got %h want %h", s, dut.age_q[s], exp_age);
            end
            vectors++;
            if (dut.valid_q[s] !== 4'b0000) begin
                miscompares++;
                $display("FAIL reset_valid set %0d: got %b want 0000", s, dut.valid_q[s]);
            end
        end
        vectors++;
        if (req_ready !== 1'b1 || done !== 1'b0 || err !== 1'b0 || done_evict !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: ready=%b done=%b err=%b evict=%b want 1 0 0 0",
                     req_ready, done, err, done_evict);
        end
    endtask

    task automatic test_miss_fill();
        logic [7:0] exp_age [4];
        logic [1:0] w;
        logic       ev, er;
        int         lat;
        exp_age[0] = {2'd2, 2'd1, 2'd0, 2'd3};
        exp_age[1] = {2'd1, 2'd0, 2'd3, 2'd2};
        exp_age[2] = {2'd0, 2'd3, 2'd2, 2'd1};
        exp_age[3] = {2'd3, 2'd2, 2'd1, 2'd0};
        for (int i = 0; i < 4; i++) begin
            do_req(3'd2, 1'b0, 2'd0, w, ev, er, lat);
            vectors++;
            if (w !== 2'(i) || ev !== 1'b0 || er !== 1'b0 || lat !== 2) begin
                miscompares++;
                $display("FAIL miss_fill %0d: way=%0d evict=%b err=%b lat=%0d want %0d 0 0 2",
                         i, w, ev, er, lat, i);
            end
            vectors++;
            if (dut.age_q[2] !== exp_age[i]) begin
                miscompares++;
                $display("FAIL miss_fill_age %0d: got %h want %h", i, dut.age_q[2], exp_age[i]);
            end
        end
        vectors++;
        if (dut.valid_q[2] !== 4'b1111) begin
            miscompares++;
            $display("FAIL miss_fill_valid: got %b want 1111", dut.valid_q[2]);
        end
    endtask

    task automatic test_hit_then_evict();
        logic [7:0] exp_age;
        logic [1:0] w;
        logic       ev, er;
        int         lat;
        do_req(3'd2, 1'b1, 2'd1, w, ev, er, lat);
        exp_age = {2'd2, 2'd1, 2'd3, 2'd0};
        vectors++;
        if (w !== 2'd1 || ev !== 1'b0 || er !== 1'b0 || dut.age_q[2] !== exp_age) begin
            miscompares++;
            $display("FAIL hit_way1: way=%0d evict=%b err=%b ages=%h want 1 0 0 %h",
                     w, ev, er, dut.age_q[2], exp_age);
        end
        do_req(3'd2, 1'b0, 2'd3, w, ev, er, lat);
        exp_age = {2'd1, 2'd0, 2'd2, 2'd3};
        vectors++;
        if (w !== 2'd0 || ev !== 1'b1 || er !== 1'b0) begin
            miscompares++;
            $display("FAIL evict_victim: way=%0d evict=%b err=%b want 0 1 0", w, ev, er);
        end
        vectors++;
        if (dut.age_q[2] !== exp_age) begin
            miscompares++;
            $display("FAIL evict_age: got %h want %h", dut.age_q[2], exp_age);
        end
    endtask

    task automatic test_hit_mru();
        logic [7:0] exp_age;
        logic [1:0] w;
        logic       ev, er;
        int         lat;
        exp_age = {2'd1, 2'd0, 2'd2, 2'd3};
        do_req(3'd2, 1'b1, 2'd0, w, ev, er, lat);
        vectors++;
        if (lat !== 2 || w !== 2'd0 || er !== 1'b0 || ev !== 1'b0) begin
            miscompares++;
            $display("FAIL hit_mru_resp: lat=%0d way=%0d err=%b evict=%b want 2 0 0 0",
                     lat, w, er, ev);
        end
        vectors++;
        if (dut.age_q[2] !== exp_age) begin
            miscompares++;
            $display("FAIL hit_mru_age: got %h want %h", dut.age_q[2], exp_age);
        end
        @(posedge clk); #1;
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL done_pulse_width: done=%b want 0", done);
        end
    endtask

    task automatic test_err();
        logic [7:0] exp_age;
        logic [1:0] w;
        logic       ev, er;
        int         lat;
        do_req(3'd5, 1'b1, 2'd2, w, ev, er, lat);
        vectors++;
        if (er !== 1'b1 || w !== 2'd2 || ev !== 1'b0) begin
            miscompares++;
            $display("FAIL err_hit_invalid: err=%b way=%0d evict=%b want 1 2 0", er, w, ev);
        end
        vectors++;
        if (dut.valid_q[5] !== 4'b0100) begin
            miscompares++;
            $display("FAIL err_valid: got %b want 0100", dut.valid_q[5]);
        end
        exp_age = {2'd2, 2'd3, 2'd1, 2'd0};
        vectors++;
        if (dut.age_q[5] !== exp_age) begin
            miscompares++;
            $display("FAIL err_age: got %h want %h", dut.age_q[5], exp_age);
        end
        exp_age = {2'd1, 2'd0, 2'd2, 2'd3};
        vectors++;
        if (dut.age_q[2] !== exp_age || dut.valid_q[2] !== 4'b1111) begin
            miscompares++;
            $display("FAIL set_isolation: ages=%h valid=%b want %h 1111",
                     dut.age_q[2], dut.valid_q[2], exp_age);
        end
    endtask

    task automatic test_flush();
        logic [7:0] exp_age;
        int         done_seen;
        exp_age   = {2'd3, 2'd2, 2'd1, 2'd0};
        @(posedge clk); #1;
        flush     = 1'b1;
        req_valid = 1'b1;
        req_set   = 3'd4;
        req_hit   = 1'b0;
        req_way   = 2'd0;
        #1;
        vectors++;
        if (req_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_ready: got %b want 0", req_ready);
        end
        @(posedge clk); #1;
        flush     = 1'b0;
        req_valid = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (done) done_seen++;
            @(posedge clk); #1;
        end
        vectors++;
        if (done_seen !== 0) begin
            miscompares++;
            $display("FAIL flush_no_accept: done pulses=%0d want 0", done_seen);
        end
        vectors++;
        if (dut.valid_q !== 32'h0 || dut.age_q[2] !== exp_age || dut.age_q[5] !== exp_age) begin
            miscompares++;
            $display("FAIL flush_arrays: valid=%h age2=%h age5=%h want 0 %h %h",
                     dut.valid_q, dut.age_q[2], dut.age_q[5], exp_age, exp_age);
        end
    endtask

    task automatic test_reset_abort();
        logic [7:0] exp_age;
        logic [1:0] w;
        logic       ev, er;
        int         lat;
        int         done_seen;
        exp_age = {2'd3, 2'd2, 2'd1, 2'd0};
        do_req(3'd1, 1'b0, 2'd0, w, ev, er, lat);
        @(posedge clk); #1;
        req_set   = 3'd1;
        req_hit   = 1'b0;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        // Now in UPDATE: abort with reset.
        reset     = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (done) done_seen++;
            @(posedge clk); #1;
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (done) done_seen++;
            @(posedge clk); #1;
        end
        vectors++;
        if (done_seen !== 0) begin
            miscompares++;
            $display("FAIL reset_abort_done: pulses=%0d want 0", done_seen);
        end
        vectors++;
        if (dut.age_q[1] !== exp_age || dut.valid_q !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_abort_arrays: age1=%h valid=%h want %h 0",
                     dut.age_q[1], dut.valid_q, exp_age);
        end
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_abort_ready: got %b want 1", req_ready);
        end
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        req_valid = 1'b0;
        req_set   = 3'd0;
        req_hit   = 1'b0;
        req_way   = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        test_reset();
        test_miss_fill();
        test_hit_then_evict();
        test_hit_mru();
        test_err();
        test_flush();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
